// File: rtl/register_writeback.sv
// Write-back stage: arbitrates execute/load results into a small FIFO that drains
// one entry per cycle onto a registered register-file write port, with pending-write forwarding.
module register_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic [4:0]               ex_waddr,
  input  logic [31:0]              ex_wdata,
  output logic                     ex_ready,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_waddr,
  input  logic [31:0]              ld_wdata,
  output logic                     ld_ready,
  output logic                     wren,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  input  logic [4:0]               fwd_raddr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wren_q, wren_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            deq_c, space_c, ld_acc_c, ex_acc_c, enq_c;
  entry_t          in_entry_c;

  // Head drains every cycle, so a full queue still has room for this cycle's request.
  assign deq_c    = (count_q != '0);
  assign space_c  = (count_q < CW'(DEPTH)) || ((count_q == CW'(DEPTH)) && deq_c);
  assign ld_ready = space_c;
  assign ex_ready = space_c & ~ld_valid;

  assign ld_acc_c   = ld_valid & space_c;
  assign ex_acc_c   = ex_valid & ex_ready;
  assign in_entry_c = ld_acc_c ? entry_t'{addr: ld_waddr, data: ld_wdata}
                               : entry_t'{addr: ex_waddr, data: ex_wdata};
  // Writes to x0 complete the handshake but are dropped here.
  assign enq_c      = (ld_acc_c | ex_acc_c) && (in_entry_c.addr != 5'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wren_d   = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (deq_c) begin
      wren_d   = 1'b1;
      waddr_d  = mem_q[rd_ptr_q].addr;
      wdata_d  = mem_q[rd_ptr_q].data;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (enq_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(enq_c) - CW'(deq_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_c) begin
      mem_q[wr_ptr_q] <= in_entry_c;
    end
  end

  // Output register is oldest; later queue matches (walked oldest to youngest) override it.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_raddr != 5'd0) begin
      if (wren_q && (waddr_q == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (mem_q[idx].addr == fwd_raddr)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_q[idx].data;
        end
      end
    end
  end

  assign wren  = wren_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign count = count_q;

endmodule
